// File: rtl/run_detector_pkg.sv
// ---------------------------------------------------------------------------
// run_detector_pkg
// Shared definitions for the multi-channel run-length detector.
//   MATCH_ZERO / MATCH_ONE : encodings of the 'target' input
//   MAX_CNT_W              : width of the count template type
//   cnt_template_t         : wide count type; modules narrow it to CNT_W
//   cnt_w(run_len)         : bits needed to hold 0..run_len (minimum 1)
// ---------------------------------------------------------------------------
package run_detector_pkg;

    localparam logic MATCH_ZERO = 1'b0;
    localparam logic MATCH_ONE  = 1'b1;

    localparam int MAX_CNT_W = 32;

    typedef logic [MAX_CNT_W-1:0] cnt_template_t;

    // Width of a saturating counter that must reach run_len inclusive.
    function automatic int cnt_w(input int run_len);
        int w;
        w = $clog2(run_len + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/run_channel.sv
// ---------------------------------------------------------------------------
// run_channel
// One channel of the run-length detector: saturating run counter, level
// decode, rise pulse register and (with RUN_DETECTOR_STICKY_EN) a sticky
// detect flag.
// Ports:
//   clock     rising-edge clock
//   reset     asynchronous, active-low
//   i_flush   target changed this cycle: discard sample, zero the count
//   i_enable  sample strobe; state holds while low
//   i_target  registered target bit value being counted
//   i_x       serial data bit for this channel
//   o_y       high while count equals RUN_LEN
//   o_rise    one-cycle pulse on the cycle o_y goes high
//   o_count   current run count
//   i_clear   sticky clear            (RUN_DETECTOR_STICKY_EN only)
//   o_sticky  latched detect flag     (RUN_DETECTOR_STICKY_EN only)
// Macro: RUN_DETECTOR_STICKY_EN
// ---------------------------------------------------------------------------
module run_channel
    import run_detector_pkg::*;
#(
    parameter  int RUN_LEN = 2,
    localparam int CNT_W   = cnt_w(RUN_LEN)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_enable,
    input  logic             i_target,
    input  logic             i_x,
    output logic             o_y,
    output logic             o_rise,
`ifdef RUN_DETECTOR_STICKY_EN
    input  logic             i_clear,
    output logic             o_sticky,
`endif
    output logic [CNT_W-1:0] o_count
);

    typedef logic [CNT_W-1:0] cnt_t;

    localparam cnt_template_t RUN_LEN_WIDE = cnt_template_t'(RUN_LEN);
    localparam cnt_t          CNT_MAX      = RUN_LEN_WIDE[CNT_W-1:0];
    localparam cnt_t          CNT_ONE      = cnt_t'(1);

    cnt_t r_cnt;
    cnt_t w_cntNext;
    logic w_match;
    logic r_rise;

    // A ones detector matches x directly, a zeros detector matches ~x.
    assign w_match = (i_target == MATCH_ONE) ? i_x : ~i_x;

    // Next count, highest priority first: flush, hold, count up, break.
    always_comb begin
        w_cntNext = r_cnt;
        if (i_flush) begin
            w_cntNext = '0;
        end else if (i_enable) begin
            if (w_match) begin
                w_cntNext = (r_cnt == CNT_MAX) ? CNT_MAX : r_cnt + CNT_ONE;
            end else begin
                w_cntNext = '0;
            end
        end
    end

    // Counter and rise register. rise only fires on the entry into
    // saturation, so it stays low while the count is held at RUN_LEN.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt  <= '0;
            r_rise <= 1'b0;
        end else begin
            r_cnt  <= w_cntNext;
            r_rise <= (w_cntNext == CNT_MAX) && (r_cnt != CNT_MAX);
        end
    end

`ifdef RUN_DETECTOR_STICKY_EN
    logic r_sticky;

    // Set beats clear when both happen on the same edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sticky <= 1'b0;
        end else if (w_cntNext == CNT_MAX) begin
            r_sticky <= 1'b1;
        end else if (i_clear) begin
            r_sticky <= 1'b0;
        end
    end

    assign o_sticky = r_sticky;
`endif

    // Level output decoded from registered state only.
    assign o_y     = (r_cnt == CNT_MAX);
    assign o_rise  = r_rise;
    assign o_count = r_cnt;

endmodule

// File: rtl/run_detector.sv
// ---------------------------------------------------------------------------
// run_detector
// Multi-channel run-length detector. Each of CHANNELS serial inputs is
// flagged once RUN_LEN consecutive enabled samples equal the target bit.
// Ports:
//   clock          rising-edge clock
//   reset          asynchronous, active-low
//   enable         sample strobe shared by all channels
//   target         bit value being counted (0 or 1)
//   x              serial data, bit i is channel i
//   y              per-channel level: count == RUN_LEN
//   rise           per-channel one-cycle pulse when y goes high
//   present_count  per-channel counts, channel i at [i*CNT_W +: CNT_W]
//   clear          sticky clear          (RUN_DETECTOR_STICKY_EN only)
//   sticky         latched detect flags  (RUN_DETECTOR_STICKY_EN only)
// Macro: RUN_DETECTOR_STICKY_EN
// ---------------------------------------------------------------------------
module run_detector
    import run_detector_pkg::*;
#(
    parameter  int CHANNELS = 4,
    parameter  int RUN_LEN  = 2,
    localparam int CNT_W    = cnt_w(RUN_LEN)
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      enable,
    input  logic                      target,
    input  logic [CHANNELS-1:0]       x,
    output logic [CHANNELS-1:0]       y,
    output logic [CHANNELS-1:0]       rise,
`ifdef RUN_DETECTOR_STICKY_EN
    input  logic                      clear,
    output logic [CHANNELS-1:0]       sticky,
`endif
    output logic [CHANNELS*CNT_W-1:0] present_count
);

    logic r_targetQ;
    logic w_flush;

    // A target change spends one edge flushing every channel; samples on
    // that edge are meaningless under either target and are dropped.
    assign w_flush = (target != r_targetQ);

    // Registered copy of target so the flush lasts exactly one cycle.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_targetQ <= MATCH_ZERO;
        end else begin
            r_targetQ <= target;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_chan
        logic [CNT_W-1:0] w_count;

        run_channel #(
            .RUN_LEN (RUN_LEN)
        ) u_chan (
            .clock    (clock),
            .reset    (reset),
            .i_flush  (w_flush),
            .i_enable (enable),
            .i_target (r_targetQ),
            .i_x      (x[g]),
            .o_y      (y[g]),
            .o_rise   (rise[g]),
`ifdef RUN_DETECTOR_STICKY_EN
            .i_clear  (clear),
            .o_sticky (sticky[g]),
`endif
            .o_count  (w_count)
        );

        assign present_count[g*CNT_W +: CNT_W] = w_count;
    end

endmodule

// File: tb/tb_run_detector.sv
// ---------------------------------------------------------------------------
// tb_run_detector
// Drives two run_detector instances (RUN_LEN 2 and 3, four channels each)
// with shared stimulus. A run-length model tracks the unbounded length of
// the current matching run per channel; the visible count is that length
// clipped at RUN_LEN. Directed sequences pin the model with literal values,
// then randomized traffic is compared every cycle.
// Macro: RUN_DETECTOR_STICKY_EN
// ---------------------------------------------------------------------------
module tb_run_detector;

    localparam int CH = 4;
    localparam int CW = 2;

    logic          clock  = 1'b0;
    logic          reset  = 1'b0;
    logic          enable = 1'b0;
    logic          target = 1'b0;
    logic          clear  = 1'b0;
    logic [CH-1:0] x      = '0;

    logic [CH-1:0]    y2, rise2, y3, rise3;
    logic [CH*CW-1:0] pc2, pc3;
    logic [CH-1:0]    sticky2, sticky3;

    int nChecks = 0;
    int nFails  = 0;

    always #5 clock = ~clock;

    run_detector #(.CHANNELS(CH), .RUN_LEN(2)) dut2 (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .target        (target),
        .x             (x),
        .y             (y2),
        .rise          (rise2),
`ifdef RUN_DETECTOR_STICKY_EN
        .clear         (clear),
        .sticky        (sticky2),
`endif
        .present_count (pc2)
    );

    run_detector #(.CHANNELS(CH), .RUN_LEN(3)) dut3 (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .target        (target),
        .x             (x),
        .y             (y3),
        .rise          (rise3),
`ifdef RUN_DETECTOR_STICKY_EN
        .clear         (clear),
        .sticky        (sticky3),
`endif
        .present_count (pc3)
    );

`ifndef RUN_DETECTOR_STICKY_EN
    assign sticky2 = '0;
    assign sticky3 = '0;
`endif

    // ---------------- reference model ----------------
    int            rl [2] = '{2, 3};
    int            mRun [2][CH];
    logic [CH-1:0] mRise [2];
    logic [CH-1:0] mSticky [2];
    logic          mTq;

    function automatic int mCount(input int d, input int ch);
        return (mRun[d][ch] < rl[d]) ? mRun[d][ch] : rl[d];
    endfunction

    always @(posedge clock or negedge reset) begin
        int oldC, newC;
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < CH; ch++) mRun[d][ch] = 0;
                mRise[d]   = '0;
                mSticky[d] = '0;
            end
            mTq = 1'b0;
        end else begin
            for (int d = 0; d < 2; d++) begin
                for (int ch = 0; ch < CH; ch++) begin
                    oldC = mCount(d, ch);
                    if (target != mTq)
                        mRun[d][ch] = 0;
                    else if (enable)
                        mRun[d][ch] = (x[ch] == mTq) ?
                                      ((mRun[d][ch] < 1000) ? mRun[d][ch] + 1 : 1000) : 0;
                    newC = mCount(d, ch);
                    mRise[d][ch] = (newC == rl[d]) && (oldC != rl[d]);
                    if (newC == rl[d])
                        mSticky[d][ch] = 1'b1;
                    else if (clear)
                        mSticky[d][ch] = 1'b0;
                end
            end
            mTq = target;
        end
    end

    // ---------------- helpers ----------------
    task automatic checkOutput(input string name, input int actual, input int expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic en, input logic tg, input logic [CH-1:0] xv,
                                 input logic cl);
        enable = en;
        target = tg;
        x      = xv;
        clear  = cl;
        @(negedge clock);
        #1;
    endtask

    function automatic int cnt2(input int ch);
        return int'(pc2[ch*CW +: CW]);
    endfunction

    function automatic int cnt3(input int ch);
        return int'(pc3[ch*CW +: CW]);
    endfunction

    // ---------------- per-cycle compare against the model ----------------
    always @(negedge clock) begin
        logic [CH-1:0]    eY [2];
        logic [CH*CW-1:0] eC [2];
        for (int d = 0; d < 2; d++) begin
            for (int ch = 0; ch < CH; ch++) begin
                eY[d][ch]         = (mCount(d, ch) == rl[d]);
                eC[d][ch*CW +: CW] = CW'(mCount(d, ch));
            end
        end
        checkOutput("model y2",     int'(y2),    int'(eY[0]));
        checkOutput("model rise2",  int'(rise2), int'(mRise[0]));
        checkOutput("model count2", int'(pc2),   int'(eC[0]));
        checkOutput("model y3",     int'(y3),    int'(eY[1]));
        checkOutput("model rise3",  int'(rise3), int'(mRise[1]));
        checkOutput("model count3", int'(pc3),   int'(eC[1]));
`ifdef RUN_DETECTOR_STICKY_EN
        checkOutput("model sticky2", int'(sticky2), int'(mSticky[0]));
        checkOutput("model sticky3", int'(sticky3), int'(mSticky[1]));
`endif
    end

    // ---------------- directed then random stimulus ----------------
    int t1x [5] = '{1, 0, 0, 0, 1};
    int t1c [5] = '{0, 1, 2, 2, 0};
    int t1y [5] = '{0, 0, 1, 1, 0};
    int t1r [5] = '{0, 0, 1, 0, 0};
    int t2x [6] = '{1, 1, 0, 1, 1, 1};
    int t2y [6] = '{0, 0, 0, 0, 0, 1};

    initial begin
        logic [CH-1:0] xv;

        // Reset state
        repeat (2) @(negedge clock);
        #1;
        checkOutput("reset y2",     int'(y2),    0);
        checkOutput("reset rise2",  int'(rise2), 0);
        checkOutput("reset count2", int'(pc2),   0);
        checkOutput("reset count3", int'(pc3),   0);
        reset = 1'b1;

        // Zero detector, RUN_LEN 2, channel 0 sees 1,0,0,0,1
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b0, {3'b000, t1x[i][0]}, 1'b0);
            checkOutput($sformatf("t1 count[0] step%0d", i), cnt2(0), t1c[i]);
            checkOutput($sformatf("t1 y[0] step%0d", i),     int'(y2[0]), t1y[i]);
            checkOutput($sformatf("t1 rise[0] step%0d", i),  int'(rise2[0]), t1r[i]);
        end

        // Saturate every channel, then flip target: all counts flush
        repeat (3) applyStimulus(1'b1, 1'b0, 4'b0000, 1'b0);
        checkOutput("sat y2", int'(y2), 15);
        checkOutput("sat y3", int'(y3), 15);
        checkOutput("sat rise2 held", int'(rise2), 0);
        applyStimulus(1'b1, 1'b1, 4'b1111, 1'b0);
        checkOutput("flush count2", int'(pc2), 0);
        checkOutput("flush count3", int'(pc3), 0);
        checkOutput("flush y3",     int'(y3),  0);

        // Ones detector, RUN_LEN 3, channel 1 sees 1,1,0,1,1,1
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b1, 1'b1, {2'b00, t2x[i][0], 1'b0}, 1'b0);
            checkOutput($sformatf("t2 y3[1] step%0d", i), int'(y3[1]), t2y[i]);
            checkOutput($sformatf("t2 count3[0] step%0d", i), cnt3(0), 0);
        end

        // Enable low holds a count of 1 on channel 2
        applyStimulus(1'b1, 1'b1, 4'b0100, 1'b0);
        checkOutput("en count2[2] start", cnt2(2), 1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b1, 4'($urandom), 1'b0);
            checkOutput($sformatf("en hold count2[2] c%0d", i), cnt2(2), 1);
            checkOutput($sformatf("en hold rise2 c%0d", i), int'(rise2), 0);
        end
        applyStimulus(1'b1, 1'b1, 4'b0100, 1'b0);
        checkOutput("en resume count2[2]", cnt2(2), 2);
        checkOutput("en resume rise2[2]",  int'(rise2[2]), 1);

`ifdef RUN_DETECTOR_STICKY_EN
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b0);
        checkOutput("sticky2[2] after break", int'(sticky2[2]), 1);
        applyStimulus(1'b1, 1'b1, 4'b0100, 1'b0);
        applyStimulus(1'b1, 1'b1, 4'b0100, 1'b1);
        checkOutput("sticky2[2] set beats clear", int'(sticky2[2]), 1);
        applyStimulus(1'b1, 1'b1, 4'b0000, 1'b1);
        checkOutput("sticky2[2] cleared", int'(sticky2[2]), 0);
`endif

        // Reset mid-run drops outputs without a clock edge
        repeat (3) applyStimulus(1'b1, 1'b1, 4'b1000, 1'b0);
        checkOutput("pre-reset y3[3]", int'(y3[3]), 1);
        reset = 1'b0;
        #1;
        checkOutput("async reset y2",     int'(y2),    0);
        checkOutput("async reset y3",     int'(y3),    0);
        checkOutput("async reset rise3",  int'(rise3), 0);
        checkOutput("async reset count2", int'(pc2),   0);
        checkOutput("async reset count3", int'(pc3),   0);
        @(negedge clock);
        reset = 1'b1;

        // Randomized traffic biased toward long runs of the target
        for (int n = 0; n < 3000; n++) begin
            logic tg;
            tg = target;
            if ($urandom_range(0, 15) == 0) tg = ~tg;
            for (int b = 0; b < CH; b++)
                xv[b] = ($urandom_range(0, 4) != 0) ? tg : ~tg;
            applyStimulus($urandom_range(0, 3) != 0, tg, xv, $urandom_range(0, 7) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/run_detector.md
# run_detector

Parametrised multi-channel run-length detector, the generalised successor of the two-zero serial detector. It watches CHANNELS independent serial bit streams and flags each channel once RUN_LEN consecutive sampled bits equal a selectable target value (0 or 1). It sits on the serial-input side of the design and feeds per-channel status and event pulses to control logic.

## Interface

- CHANNELS, default 4: number of independent serial inputs; must be 1 or more.
- RUN_LEN, default 2: consecutive-match threshold; must be 1 or more.
- CNT_W, derived local constant (not overridable): $clog2(RUN_LEN+1), minimum 1.

Ports:

- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- enable  in  1  sample strobe. When high, x is sampled on the clock edge. When low, all state holds.
- target  in  1  bit value being counted. 0 gives a zero detector, 1 gives a ones detector.
- x  in  CHANNELS  serial data. Bit i belongs to channel i.
- y  out  CHANNELS  level output: high while channel count equals RUN_LEN.
- rise  out  CHANNELS  one-cycle pulse on the cycle y[i] goes high.
- present_count  out  CHANNELS*CNT_W  per-channel run count; channel i occupies bits [i*CNT_W +: CNT_W].
- clear  in  1  sticky clear. Present only with RUN_DETECTOR_STICKY_EN.
- sticky  out  CHANNELS  latched detect flags. Present only with RUN_DETECTOR_STICKY_EN.

## Operation

- Per channel, cnt is a saturating counter in the range 0..RUN_LEN. It is the Moore state of the channel.
- target_q is an internal register copy of target.
- Next-state rules for each channel, highest priority first:
  1. target != target_q: cnt <= 0 on every channel, regardless of enable and x. target_q <= target.
  2. enable = 0: cnt holds.
  3. x[i] == target_q: cnt <= min(cnt+1, RUN_LEN). The count saturates and never wraps.
  4. Otherwise: cnt <= 0.
- y[i] is decoded from the registered state only: y[i] = (cnt == RUN_LEN). There is no combinational path from x to y.
- rise[i] is a register: rise[i] <= (cnt_next == RUN_LEN) & (cnt != RUN_LEN).
  - rise[i] is 0 while y[i] stays high through saturation.
- Channels are fully independent. Only target and enable are shared.
- RUN_LEN = 1: cnt is 1 bit, and y follows a registered (x == target_q) whenever enable is high.

## Timing

- Reset values: cnt = 0 on all channels, target_q = 0, y = 0, rise = 0, present_count = 0, sticky = 0.
- Reset is asynchronous assert. Deassertion is synchronised externally. Reset mid-run drops all outputs immediately.
- Latency, measured in enabled edges: after the RUN_LEN-th consecutive matching sample edge, y[i] and rise[i] are high.
  - rise[i] is high for that single cycle only.
- A single non-matching enabled sample drops y[i] low after that edge.
- With enable low, y, present_count and sticky hold. rise is 0 during those cycles.
- A change on target costs one cycle in which all samples are discarded. The first valid sample under the new target is on the next edge.

## Configuration

- Macro: RUN_DETECTOR_STICKY_EN.
- Defined:
  - The clear input and sticky output exist.
  - sticky[i] <= 1 when cnt_next == RUN_LEN. Otherwise sticky[i] <= 0 if clear is high, else it holds.
  - If set and clear occur in the same cycle, set wins.
  - A target change does not clear sticky.
- Undefined: the clear and sticky ports are absent, with no sticky logic. All other behaviour is identical.

## Structure

- Package run_detector_pkg holds:
  - the count-width function, cnt_w(run_len);
  - the channel count typedef template;
  - the MATCH_ZERO / MATCH_ONE constants for target.
- Sub-module run_channel holds one channel: counter, y decode, rise register and optional sticky. It is instantiated CHANNELS times in a generate loop.
- The top level holds target_q, the target-change flush and the port packing.

## Test plan

- RUN_LEN=2, target=0, enable=1, x[0] = 1,0,0,0,1 on successive edges:
  - present_count[0] = 0,1,2,2,0;
  - y[0] high after the 3rd edge and through the 4th;
  - rise[0] high for exactly one cycle.
- RUN_LEN=3, target=1, x[1] = 1,1,0,1,1,1: y[1] first high after the 6th edge. Channel 0, held at 0, stays 0 throughout.
- enable toggled low mid-run (count 1): count holds through 4 disabled cycles, and the next enabled match brings count to 2.
- target flipped 0 to 1 while cnt = RUN_LEN on all channels: all counts are 0 the next cycle and y drops. That edge's sample is ignored.
- reset pulsed low while y = 1: y, rise and present_count go to 0 without a clock edge.
- RUN_DETECTOR_STICKY_EN defined:
  - sticky[2] stays set after the run breaks;
  - clear asserted on the same edge as a new detect leaves sticky[2] at 1;
  - clear asserted alone drives sticky[2] to 0.
